// File: rtl/cby_pipe_if.sv
// Channel and configuration-chain bundle for the pipelined Y connection block.
// The master drives tracks and config; the slave is the block itself.
interface cby_pipe_if #(
    parameter int CHAN_WIDTH = 32
);
    logic                  config_enable;
    logic                  ccff_head;
    logic                  ccff_tail;
    logic [0:CHAN_WIDTH-1] chany_bottom_in;
    logic [0:CHAN_WIDTH-1] chany_top_in;
    logic [0:CHAN_WIDTH-1] chany_bottom_out;
    logic [0:CHAN_WIDTH-1] chany_top_out;

    modport master (
        output config_enable, ccff_head, chany_bottom_in, chany_top_in,
        input  ccff_tail, chany_bottom_out, chany_top_out
    );

    modport slave (
        input  config_enable, ccff_head, chany_bottom_in, chany_top_in,
        output ccff_tail, chany_bottom_out, chany_top_out
    );
endinterface

// File: rtl/cby_pipe.sv
// Y-channel connection block with per-track bypass/registered mode
// selected by a serial configuration chain.
module cby_pipe #(
    parameter int CHAN_WIDTH  = 32,
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       reset,
    cby_pipe_if.slave  bus
);
    localparam int NCFG = 2 * CHAN_WIDTH;

    logic [0:NCFG-1]       r_cfg;
    logic [0:CHAN_WIDTH-1] r_up [PIPE_STAGES];
    logic [0:CHAN_WIDTH-1] r_dn [PIPE_STAGES];

    logic [0:CHAN_WIDTH-1] w_top_mode;
    logic [0:CHAN_WIDTH-1] w_bot_mode;
    logic [0:CHAN_WIDTH-1] w_top_sel;
    logic [0:CHAN_WIDTH-1] w_bot_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (bus.config_enable) begin
            r_cfg <= {bus.ccff_head, r_cfg[0:NCFG-2]};
        end
    end

    // Pipes run every cycle so a track switched to registered shows valid data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_up[s] <= '0;
                r_dn[s] <= '0;
            end
        end else begin
            r_up[0] <= bus.chany_bottom_in;
            r_dn[0] <= bus.chany_top_in;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_up[s] <= r_up[s-1];
                r_dn[s] <= r_dn[s-1];
            end
        end
    end

    assign w_top_mode = r_cfg[0:CHAN_WIDTH-1];
    assign w_bot_mode = r_cfg[CHAN_WIDTH:NCFG-1];

    assign w_top_sel = (w_top_mode & r_up[PIPE_STAGES-1])
                     | (~w_top_mode & bus.chany_bottom_in);
    assign w_bot_sel = (w_bot_mode & r_dn[PIPE_STAGES-1])
                     | (~w_bot_mode & bus.chany_top_in);

    // Blank while shifting so half-loaded configs never reach the fabric
    assign bus.chany_top_out    = bus.config_enable ? '0 : w_top_sel;
    assign bus.chany_bottom_out = bus.config_enable ? '0 : w_bot_sel;
    assign bus.ccff_tail        = r_cfg[NCFG-1];
endmodule

// File: tb/tb_cby_pipe.sv
// Directed bench for cby_pipe with CHAN_WIDTH=32, PIPE_STAGES=2.
// Expected values are hand-computed per step.
module tb_cby_pipe;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [63:0] pat;
    logic [31:0] w_exp;

    cby_pipe_if #(.CHAN_WIDTH(32)) bus ();

    cby_pipe #(
        .CHAN_WIDTH (32),
        .PIPE_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic b);
        bus.ccff_head     = b;
        bus.config_enable = 1'b1;
        step();
    endtask

    function automatic logic [31:0] walk(input int j);
        logic [31:0] one;
        one = 32'h8000_0000;
        return (j >= 0 && j < 8) ? (one >> j) : 32'h0;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.config_enable   = 1'b0;
        bus.ccff_head       = 1'b0;
        bus.chany_bottom_in = 32'hA5A5_A5A5;
        bus.chany_top_in    = 32'h0F0F_0F0F;
        #2;

        // 1: reset state, bypass
        chk("rst_top", {32'h0, bus.chany_top_out}, {32'h0, 32'hA5A5_A5A5});
        chk("rst_bot", {32'h0, bus.chany_bottom_out}, {32'h0, 32'h0F0F_0F0F});
        chk("rst_tail", {63'h0, bus.ccff_tail}, 64'h0);
        step();
        reset = 1'b0;
        step();
        chk("t1_top", {32'h0, bus.chany_top_out}, {32'h0, 32'hA5A5_A5A5});
        chk("t1_bot", {32'h0, bus.chany_bottom_out}, {32'h0, 32'h0F0F_0F0F});

        // 2: only top_out[0] registered
        bus.chany_bottom_in = 32'h25A5_A5A5;
        for (int i = 0; i < 64; i++) begin
            shift(i == 63);
            if (i == 9 || i == 63) begin
                chk("t2_blank_top", {32'h0, bus.chany_top_out}, 64'h0);
                chk("t2_blank_bot", {32'h0, bus.chany_bottom_out}, 64'h0);
            end
        end
        bus.config_enable = 1'b0;
        #1;
        chk("t2_top_init", {32'h0, bus.chany_top_out}, {32'h0, 32'h25A5_A5A5});
        chk("t2_bot_init", {32'h0, bus.chany_bottom_out}, {32'h0, 32'h0F0F_0F0F});
        chk("t2_tail", {63'h0, bus.ccff_tail}, 64'h0);
        bus.chany_bottom_in = 32'hA5A5_A5A5;
        #1;
        chk("t2_top_e0", {32'h0, bus.chany_top_out}, {32'h0, 32'h25A5_A5A5});
        step();
        chk("t2_top_e1", {32'h0, bus.chany_top_out}, {32'h0, 32'h25A5_A5A5});
        bus.chany_bottom_in = 32'hA5A5_A5A4;
        #1;
        chk("t2_bypass_lsb", {32'h0, bus.chany_top_out}, {32'h0, 32'h25A5_A5A4});
        step();
        chk("t2_top_e2", {32'h0, bus.chany_top_out}, {32'h0, 32'hA5A5_A5A4});
        bus.chany_top_in = 32'h1234_5678;
        #1;
        chk("t2_bot_bypass", {32'h0, bus.chany_bottom_out}, {32'h0, 32'h1234_5678});

        // 3: every track registered, walking one
        for (int i = 0; i < 64; i++) shift(1'b1);
        chk("t3_tail", {63'h0, bus.ccff_tail}, 64'h1);
        bus.config_enable   = 1'b0;
        bus.chany_bottom_in = 32'hFFFF_FFFF;
        bus.chany_top_in    = 32'h0;
        step();
        step();
        chk("t3_top_fill", {32'h0, bus.chany_top_out}, {32'h0, 32'hFFFF_FFFF});
        chk("t3_bot_fill", {32'h0, bus.chany_bottom_out}, 64'h0);
        for (int k = 0; k < 10; k++) begin
            bus.chany_top_in    = walk(k);
            bus.chany_bottom_in = ~walk(k);
            step();
            w_exp = walk(k - 1);
            chk("t3_bot_walk", {32'h0, bus.chany_bottom_out}, {32'h0, w_exp});
            chk("t3_top_walk", {32'h0, bus.chany_top_out}, {32'h0, ~w_exp});
        end

        // 5: blanking while shifting ones, then hold with enable low
        bus.chany_bottom_in = 32'hFFFF_FFFF;
        bus.config_enable   = 1'b1;
        bus.ccff_head       = 1'b1;
        #1;
        chk("t5_blank_now", {32'h0, bus.chany_top_out}, 64'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_blank_top", {32'h0, bus.chany_top_out}, 64'h0);
            chk("t5_blank_bot", {32'h0, bus.chany_bottom_out}, 64'h0);
        end
        bus.config_enable   = 1'b0;
        bus.chany_bottom_in = 32'h1234_5678;
        #1;
        chk("t5_top_hold0", {32'h0, bus.chany_top_out}, {32'h0, 32'hFFFF_FFFF});
        bus.ccff_head = 1'b0;
        step();
        chk("t5_top_hold1", {32'h0, bus.chany_top_out}, {32'h0, 32'hFFFF_FFFF});
        bus.ccff_head = 1'b1;
        step();
        chk("t5_top_hold2", {32'h0, bus.chany_top_out}, {32'h0, 32'h1234_5678});
        chk("t5_bot_hold", {32'h0, bus.chany_bottom_out}, 64'h0);
        chk("t5_tail", {63'h0, bus.ccff_tail}, 64'h1);

        // 6: asynchronous reset mid-shift
        bus.chany_bottom_in = 32'hCAFE_F00D;
        bus.chany_top_in    = 32'h0BAD_BEEF;
        shift(1'b0);
        shift(1'b0);
        shift(1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_top_blank", {32'h0, bus.chany_top_out}, 64'h0);
        chk("t6_rst_tail", {63'h0, bus.ccff_tail}, 64'h0);
        bus.config_enable = 1'b0;
        #1;
        chk("t6_rst_top", {32'h0, bus.chany_top_out}, {32'h0, 32'hCAFE_F00D});
        chk("t6_rst_bot", {32'h0, bus.chany_bottom_out}, {32'h0, 32'h0BAD_BEEF});
        bus.chany_bottom_in = 32'h0;
        bus.chany_top_in    = 32'h0;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) shift(1'b1);
        bus.config_enable   = 1'b0;
        bus.chany_bottom_in = 32'hFFFF_FFFF;
        bus.chany_top_in    = 32'hFFFF_FFFF;
        #1;
        chk("t6_rereg_top", {32'h0, bus.chany_top_out}, 64'h0);
        chk("t6_rereg_bot", {32'h0, bus.chany_bottom_out}, 64'h0);

        // 4: chain pass-through
        reset = 1'b1;
        #1;
        reset = 1'b0;
        pat = 64'hDEAD_BEEF_1234_5678;
        for (int i = 63; i >= 0; i--) shift(pat[i]);
        for (int j = 0; j < 64; j++) begin
            chk("t4_tail", {63'h0, bus.ccff_tail}, {63'h0, pat[63-j]});
            shift(1'b0);
        end
        chk("t4_tail_end", {63'h0, bus.ccff_tail}, 64'h0);
        bus.config_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
